uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one handshaking UART transmitter among NUM_REQ byte-stream requesters.
//  Round-robin grant with packet lock: once granted, a requester keeps the transmitter
//  until its byte flagged req_last has fully completed on the line.
//  Sits between the message sources and the transmitter's tx_dv/tx_byte/tx_active/tx_done pins.
// PARAMETERS
//  NUM_REQ       4    number of requesters (2..8)
//  ISSUE_TIMEOUT 255  cycles tx_dv may be held without tx_active rising (e.g. CTS low) before abort
// PORTS
//  clk        in   1           clock
//  reset      in   1           asynchronous, active-high reset
//  req_valid  in   NUM_REQ     requester i has a byte on req_data[8i+:8]
//  req_data   in   8*NUM_REQ   packed bytes, requester i at [8i+7:8i]
//  req_last   in   NUM_REQ     byte from requester i ends its packet
//  req_ready  out  NUM_REQ     one-cycle accept pulse; byte of requester i is consumed
//  tx_dv      out  1           data-valid to transmitter, held until tx_active seen
//  tx_byte    out  8           byte to transmitter, stable while tx_dv high
//  tx_active  in   1           transmitter busy
//  tx_done    in   1           transmitter completion (may stay high >1 cycle)
//  grant_id   out  3           index of the current owner (valid when busy)
//  busy       out  1           a packet is in progress
//  timeout    out  1           one-cycle pulse: issue aborted by ISSUE_TIMEOUT
// BEHAVIOUR
//  Reset: state IDLE, req_ready=0, tx_dv=0, tx_byte=0, grant_id=0, busy=0, timeout=0,
//   rr pointer=0 (requester 0 has highest priority after reset). Reset mid-packet aborts it.
//  States: IDLE -> ISSUE -> WAIT_DONE -> GAP -> (ISSUE | IDLE).
//  IDLE: if any req_valid, pick first valid index at or after rr pointer (wrapping);
//   set grant_id, busy=1, latch byte into tx_byte, pulse req_ready[grant], go ISSUE.
//   Latency: req_valid high -> req_ready pulse on the next edge -> tx_dv high the same cycle.
//  ISSUE: tx_dv=1, count cycles. tx_active=1 -> tx_dv=0, go WAIT_DONE.
//   count reaches ISSUE_TIMEOUT -> tx_dv=0, pulse timeout, release grant, go IDLE;
//   the latched byte is dropped (already accepted).
//  WAIT_DONE: wait for tx_done=1, then go GAP.
//  GAP: wait until tx_done=0 and tx_active=0 (transmitter back in idle). Then:
//   latched byte had last=1 -> busy=0, rr pointer = grant_id+1 mod NUM_REQ, go IDLE;
//   else if req_valid[grant_id] -> accept next byte (req_ready pulse), go ISSUE;
//   else stay in GAP holding the grant (packet lock; no other requester served).
//  Only the granted requester ever sees req_ready; at most one req_ready bit high per cycle.
//  req_last sampled together with req_data at the accept cycle.
//  Simultaneous requests in IDLE: rr order decides; ungranted requests wait, never lost.
//  NUM_REQ=1 behaves as a pass-through with packet framing.
//  tx_done seen high in ISSUE (stale) is ignored; only tx_active advances ISSUE.
// TESTING
//  Single byte: req0 0x55 last=1 -> one req_ready[0] pulse, tx_dv until tx_active, busy drops after tx_done falls.
//  Contention: req0..req3 all valid, 1-byte packets -> service order 0,1,2,3, then 0 again; no repeats.
//  Packet lock: req1 sends 3 bytes (last on 3rd) while req2 valid -> req2 waits until req1 byte 3 done.
//  Stall in lock: req1 drops valid mid-packet for 50 cycles -> arbiter stays in GAP, grant_id=1, req2 not served.
//  CTS held low, ISSUE_TIMEOUT=16 -> tx_dv high exactly 16 cycles, timeout pulse, busy=0, next requester served.
//  Reset asserted during WAIT_DONE -> all outputs to reset values next cycle; rr pointer back to 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one handshaking UART transmitter among NUM_REQ byte
// streams; a granted requester keeps the transmitter until its last byte has completed.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int ISSUE_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_dv,
    output logic [7:0]             tx_byte,
    input  logic                   tx_active,
    input  logic                   tx_done,
    output logic [2:0]             grant_id,
    output logic                   busy,
    output logic                   timeout
);

    localparam int CW = (ISSUE_TIMEOUT < 2) ? 1 : $clog2(ISSUE_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_GAP       = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic                 tx_dv_q, tx_dv_d;
    logic [7:0]           tx_byte_q, tx_byte_d;
    logic [2:0]           grant_q, grant_d;
    logic                 busy_q, busy_d;
    logic                 timeout_q, timeout_d;
    logic [2:0]           rr_q, rr_d;
    logic                 last_q, last_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic [NUM_REQ-1:0]   hi_mask_s;
    logic [NUM_REQ-1:0]   cand_s;
    logic [2:0]           pick_idx_s;
    logic [7:0]           pick_data_s;
    logic                 pick_last_s;
    logic                 g_valid_s;
    logic [7:0]           g_data_s;
    logic                 g_last_s;
    logic [2:0]           next_rr_s;

    // Round-robin pick: lowest valid index at/after rr pointer, else lowest valid overall.
    always_comb begin
        hi_mask_s   = '0;
        pick_idx_s  = 3'd0;
        pick_data_s = 8'd0;
        pick_last_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hi_mask_s[i] = req_valid[i] & (3'(i) >= rr_q);
        end
        cand_s = (|hi_mask_s) ? hi_mask_s : req_valid;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            pick_idx_s = cand_s[i] ? 3'(i) : pick_idx_s;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_data_s = (pick_idx_s == 3'(i)) ? req_data[8*i +: 8] : pick_data_s;
            pick_last_s = (pick_idx_s == 3'(i)) ? req_last[i] : pick_last_s;
        end
    end

    // Select the current owner's request lines without a variable part-select.
    always_comb begin
        g_valid_s = 1'b0;
        g_data_s  = 8'd0;
        g_last_s  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            g_valid_s = (grant_q == 3'(i)) ? req_valid[i]       : g_valid_s;
            g_data_s  = (grant_q == 3'(i)) ? req_data[8*i +: 8] : g_data_s;
            g_last_s  = (grant_q == 3'(i)) ? req_last[i]        : g_last_s;
        end
        next_rr_s = (grant_q == 3'(NUM_REQ - 1)) ? 3'd0 : grant_q + 3'd1;
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        req_ready_d = '0;
        tx_dv_d     = tx_dv_q;
        tx_byte_d   = tx_byte_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        timeout_d   = 1'b0;
        rr_d        = rr_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    grant_d     = pick_idx_s;
                    busy_d      = 1'b1;
                    tx_byte_d   = pick_data_s;
                    last_d      = pick_last_s;
                    req_ready_d = NUM_REQ'(1'b1) << pick_idx_s;
                    tx_dv_d     = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_ISSUE;
                end else begin
                    tx_dv_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            S_ISSUE: begin
                if (tx_active) begin
                    tx_dv_d = 1'b0;
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == CW'(ISSUE_TIMEOUT - 1)) begin
                    // Transmitter never started (e.g. CTS low): drop the accepted byte.
                    tx_dv_d   = 1'b0;
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    rr_d      = next_rr_s;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (tx_done) begin
                    state_d = S_GAP;
                end else begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_GAP: begin
                if (!tx_done && !tx_active) begin
                    if (last_q) begin
                        busy_d  = 1'b0;
                        rr_d    = next_rr_s;
                        state_d = S_IDLE;
                    end else if (g_valid_s) begin
                        tx_byte_d   = g_data_s;
                        last_d      = g_last_s;
                        req_ready_d = NUM_REQ'(1'b1) << grant_q;
                        tx_dv_d     = 1'b1;
                        cnt_d       = '0;
                        state_d     = S_ISSUE;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    state_d = S_GAP;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_dv_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            req_ready_q <= '0;
            tx_dv_q     <= 1'b0;
            tx_byte_q   <= 8'd0;
            grant_q     <= 3'd0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            rr_q        <= 3'd0;
            last_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            tx_dv_q     <= tx_dv_d;
            tx_byte_q   <= tx_byte_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            rr_q        <= rr_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready = req_ready_q;
    assign tx_dv     = tx_dv_q;
    assign tx_byte   = tx_byte_q;
    assign grant_id  = grant_q;
    assign busy      = busy_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: behavioural requesters and transmitter, logs of
// accepts/transmitted bytes, and hand-computed expected orders.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = 4'd0;
    logic [31:0] req_data = 32'd0;
    logic [3:0]  req_last = 4'd0;
    logic [3:0]  req_ready;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_active = 1'b0;
    logic        tx_done = 1'b0;
    logic [2:0]  grant_id;
    logic        busy;
    logic        timeout;

    int n_total = 0;
    int n_bad   = 0;

    logic [8:0] mem [4][16];
    int  hd [4] = '{default: 0};
    int  tl [4] = '{default: 0};
    logic cts = 1'b1;

    int  acc_log [32];
    int  sent_log [32];
    int  run_log [32];
    int  n_acc = 0, n_sent = 0, n_run = 0, run_len = 0;
    int  tphase = 0, tcnt = 0;
    int  ready_err = 0, busy_err = 0;

    int e3_src [5] = '{0, 1, 2, 3, 0};
    int e3_byte [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0};
    int e4_src [4] = '{1, 1, 1, 2};
    int e4_byte [4] = '{8'hC1, 8'hC2, 8'hC3, 8'hD0};

    uart_tx_arbiter #(.NUM_REQ(4), .ISSUE_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_dv(tx_dv), .tx_byte(tx_byte),
        .tx_active(tx_active), .tx_done(tx_done), .grant_id(grant_id), .busy(busy),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] b, input logic last);
        mem[i][tl[i] % 16] = {last, b};
        tl[i]++;
    endtask

    task automatic clear_logs();
        n_acc = 0; n_sent = 0; n_run = 0;
    endtask

    task automatic flush_all();
        for (int i = 0; i < 4; i++) tl[i] = hd[i];
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        flush_all();
        @(posedge clk); #1 reset = 1'b0;
    endtask

    // Wait (bounded) for n accepts and a fully idle arbiter/transmitter.
    task automatic wait_acc(input string tag, input int n);
        for (int k = 0; k < 400 && !(n_acc >= n && !busy && tphase == 0); k++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk(tag, n_acc, n);
    endtask

    // Requester queues, transmitter model and monitors, all away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            tphase = 0; tcnt = 0; tx_active = 1'b0; tx_done = 1'b0; run_len = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (req_ready[i]) begin
                    if (n_acc < 32) acc_log[n_acc] = i;
                    n_acc++;
                    hd[i]++;
                end
            end
            if (req_ready != 4'd0 && req_ready != (4'b0001 << grant_id)) ready_err++;
            if (tphase != 0 && !busy) busy_err++;
            if (tx_dv) run_len++;
            else if (run_len > 0) begin
                if (n_run < 32) run_log[n_run] = run_len;
                n_run++;
                run_len = 0;
            end
            if (tphase == 0) begin
                if (tx_dv && cts) begin
                    tx_active = 1'b1; tcnt = 0; tphase = 1;
                    if (n_sent < 32) sent_log[n_sent] = tx_byte;
                    n_sent++;
                end
            end else begin
                tcnt++;
                if (tcnt == 3) begin
                    tx_active = 1'b0; tx_done = 1'b1;
                end else if (tcnt == 5) begin
                    tx_done = 1'b0; tphase = 0;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            req_valid[i]       = (hd[i] < tl[i]);
            req_data[8*i +: 8] = mem[i][hd[i] % 16][7:0];
            req_last[i]        = mem[i][hd[i] % 16][8];
        end
    end

    initial begin
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 16; j++) mem[i][j] = 9'd0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 4'd0);
        chk("rst_dv", tx_dv, 1'b0);
        chk("rst_byte", tx_byte, 8'd0);
        chk("rst_grant", grant_id, 3'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        @(posedge clk); #1 reset = 1'b0;

        // Single byte from req0
        clear_logs();
        push(0, 8'h55, 1'b1);
        for (int k = 0; k < 20 && req_ready == 4'd0; k++) @(negedge clk);
        chk("t1_ready", req_ready, 4'b0001);
        chk("t1_dv", tx_dv, 1'b1);
        chk("t1_byte_out", tx_byte, 8'h55);
        chk("t1_busy", busy, 1'b1);
        chk("t1_grant", grant_id, 3'd0);
        wait_acc("t1_acc", 1);
        chk("t1_src", acc_log[0], 0);
        chk("t1_sent_n", n_sent, 1);
        chk("t1_sent", sent_log[0], 8'h55);
        chk("t1_dvlen", run_log[0], 1);

        // Contention, rr restarts at 0 after reset
        do_reset();
        clear_logs();
        for (int i = 0; i < 4; i++) push(i, 8'(8'hA0 + i), 1'b1);
        push(0, 8'hB0, 1'b1);
        wait_acc("t3_acc", 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_src%0d", i), acc_log[i], e3_src[i]);
            chk($sformatf("t3_byte%0d", i), sent_log[i], e3_byte[i]);
        end

        // Packet lock: req1 three bytes, req2 waits
        clear_logs();
        push(1, 8'hC1, 1'b0); push(1, 8'hC2, 1'b0); push(1, 8'hC3, 1'b1);
        push(2, 8'hD0, 1'b1);
        wait_acc("t4_acc", 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_src%0d", i), acc_log[i], e4_src[i]);
            chk($sformatf("t4_byte%0d", i), sent_log[i], e4_byte[i]);
        end

        // Stall inside a packet: grant held, req2 not served
        do_reset();
        clear_logs();
        push(1, 8'hE1, 1'b0);
        push(2, 8'hF0, 1'b1);
        repeat (70) @(negedge clk);
        chk("t5_grant", grant_id, 3'd1);
        chk("t5_busy", busy, 1'b1);
        chk("t5_dv", tx_dv, 1'b0);
        chk("t5_nacc", n_acc, 1);
        @(posedge clk); #1 push(1, 8'hE2, 1'b1);
        wait_acc("t5_acc", 3);
        chk("t5_src1", acc_log[1], 1);
        chk("t5_src2", acc_log[2], 2);
        chk("t5_byte1", sent_log[1], 8'hE2);
        chk("t5_byte2", sent_log[2], 8'hF0);

        // Issue timeout with CTS low, then the next requester is served
        clear_logs();
        cts = 1'b0;
        push(3, 8'h77, 1'b1);
        push(0, 8'h88, 1'b1);
        for (int k = 0; k < 60 && !timeout; k++) @(negedge clk);
        chk("t6_to", timeout, 1'b1);
        chk("t6_busy", busy, 1'b0);
        chk("t6_dv", tx_dv, 1'b0);
        cts = 1'b1;
        @(negedge clk);
        chk("t6_to_pulse", timeout, 1'b0);
        chk("t6_next_grant", grant_id, 3'd0);
        chk("t6_next_busy", busy, 1'b1);
        wait_acc("t6_acc", 2);
        chk("t6_src0", acc_log[0], 3);
        chk("t6_src1", acc_log[1], 0);
        chk("t6_sent_n", n_sent, 1);
        chk("t6_sent", sent_log[0], 8'h88);
        chk("t6_run0", run_log[0], 16);
        chk("t6_run1", run_log[1], 1);

        // Reset during WAIT_DONE
        clear_logs();
        push(2, 8'h3C, 1'b0); push(2, 8'h3D, 1'b1);
        for (int k = 0; k < 40 && !tx_active; k++) @(negedge clk);
        @(posedge clk); #1;
        chk("t7_pre_busy", busy, 1'b1);
        chk("t7_pre_grant", grant_id, 3'd2);
        reset = 1'b1;
        flush_all();
        @(negedge clk);
        chk("t7_ready", req_ready, 4'd0);
        chk("t7_dv", tx_dv, 1'b0);
        chk("t7_byte", tx_byte, 8'd0);
        chk("t7_grant", grant_id, 3'd0);
        chk("t7_busy", busy, 1'b0);
        chk("t7_timeout", timeout, 1'b0);
        @(posedge clk); #1 reset = 1'b0;
        clear_logs();
        push(3, 8'h4B, 1'b1);
        push(0, 8'h4A, 1'b1);
        wait_acc("t7_acc", 2);
        chk("t7_src0", acc_log[0], 0);
        chk("t7_src1", acc_log[1], 3);

        chk("ready_onehot", ready_err, 0);
        chk("busy_hold", busy_err, 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
